// File: rtl/sseg_display_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with a two-source arbiter.
// Background source A owns the display unless priority source B holds a timed grant.
module sseg_display_ctrl #(
   parameter int unsigned CLK_DIV      = 50000,
   parameter int unsigned BLANK_CYCLES = 500,
   parameter int unsigned HOLD_FRAMES  = 200
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [15:0] i_a_value,
   input  logic        i_b_req,
   input  logic [15:0] i_b_value,
   output logic        o_b_ack,
   output logic        o_b_done,
   output logic        o_owner,
   output logic        o_frame_tick,
   output logic [3:0]  o_grounds,
   output logic [6:0]  o_display
);

   // state  | meaning
   // A_OWN  | background value shown, shadow refreshed from a_value each frame
   // B_OWN  | priority value held for frames_left more frame boundaries
   typedef enum logic {
      A_OWN = 1'b0,
      B_OWN = 1'b1
   } state_t;

   localparam int unsigned SW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned FW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES + 1) : 1;

   localparam logic [SW-1:0] SLOT_LAST = SW'(CLK_DIV - 1);
   localparam logic [SW:0]   BLANK_TH  = (SW+1)'(CLK_DIV - BLANK_CYCLES);
   localparam logic [FW-1:0] HOLD_LOAD = FW'(HOLD_FRAMES);
   localparam logic [FW-1:0] FRAME_ONE = FW'(1);

   // slot counter runs down: remaining cycles in the current digit slot
   logic [SW-1:0] r_slot_rem;
   logic [1:0]    r_digit;
   logic [15:0]   r_shadow;
   logic [FW-1:0] r_frames_left;
   state_t        r_state;
   logic          r_b_ack;
   logic          r_b_done;
   logic          r_frame_tick;
   logic [3:0]    r_grounds;
   logic [6:0]    r_display;

   logic          w_slot_tc;
   logic          w_boundary;
   logic          w_blank;
   logic [3:0]    w_nibble;
   logic [6:0]    w_seg;

   assign w_slot_tc  = (r_slot_rem == '0);
   assign w_boundary = w_slot_tc && (r_digit == 2'd3);
   // remaining count at or above the threshold means slot_cnt < BLANK_CYCLES
   assign w_blank    = ({1'b0, r_slot_rem} >= BLANK_TH);
   assign w_nibble   = r_shadow[{r_digit, 2'b00} +: 4];

   always_comb begin
      w_seg = 7'b0000000;
      case (w_nibble)
         4'h0: w_seg = 7'b1111110;
         4'h1: w_seg = 7'b0110000;
         4'h2: w_seg = 7'b1101101;
         4'h3: w_seg = 7'b1111001;
         4'h4: w_seg = 7'b0110011;
         4'h5: w_seg = 7'b1011011;
         4'h6: w_seg = 7'b1011111;
         4'h7: w_seg = 7'b1110000;
         4'h8: w_seg = 7'b1111111;
         4'h9: w_seg = 7'b1111011;
         4'hA: w_seg = 7'b1110111;
         4'hB: w_seg = 7'b0011111;
         4'hC: w_seg = 7'b1001110;
         4'hD: w_seg = 7'b0111101;
         4'hE: w_seg = 7'b1001111;
         4'hF: w_seg = 7'b1000111;
         default: w_seg = 7'b0000000;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_slot_rem <= SLOT_LAST;
         r_digit    <= 2'd0;
      end else if (w_slot_tc) begin
         r_slot_rem <= SLOT_LAST;
         r_digit    <= r_digit + 2'd1;
      end else begin
         r_slot_rem <= r_slot_rem - 1'b1;
      end
   end

   // pin drivers lag the scan state by exactly one cycle
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_grounds <= 4'b1111;
         r_display <= 7'b0000000;
      end else if (w_blank) begin
         r_grounds <= 4'b1111;
         r_display <= 7'b0000000;
      end else begin
         r_grounds <= ~(4'b0001 << r_digit);
         r_display <= w_seg;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state       <= A_OWN;
         r_shadow      <= 16'h0000;
         r_frames_left <= '0;
         r_b_ack       <= 1'b0;
         r_b_done      <= 1'b0;
         r_frame_tick  <= 1'b0;
      end else begin
         r_b_ack      <= 1'b0;
         r_b_done     <= 1'b0;
         r_frame_tick <= w_boundary;
         if (w_boundary) begin
            case (r_state)
               A_OWN: begin
                  if (i_b_req) begin
                     r_shadow      <= i_b_value;
                     r_b_ack       <= 1'b1;
                     r_frames_left <= HOLD_LOAD;
                     r_state       <= B_OWN;
                  end else begin
                     r_shadow <= i_a_value;
                  end
               end
               B_OWN: begin
                  if (r_frames_left > FRAME_ONE) begin
                     r_frames_left <= r_frames_left - FRAME_ONE;
                  end else begin
                     r_b_done <= 1'b1;
                     if (i_b_req) begin
                        // back-to-back grant: release and re-acquire in one boundary
                        r_shadow      <= i_b_value;
                        r_b_ack       <= 1'b1;
                        r_frames_left <= HOLD_LOAD;
                     end else begin
                        r_shadow      <= i_a_value;
                        r_frames_left <= '0;
                        r_state       <= A_OWN;
                     end
                  end
               end
               default: r_state <= A_OWN;
            endcase
         end
      end
   end

   assign o_b_ack      = r_b_ack;
   assign o_b_done     = r_b_done;
   assign o_owner      = (r_state == B_OWN);
   assign o_frame_tick = r_frame_tick;
   assign o_grounds    = r_grounds;
   assign o_display    = r_display;

endmodule

// File: tb/tb_sseg_display_ctrl.sv
// Bench for sseg_display_ctrl: directed scenarios plus random traffic, every cycle
// compared against a frame-position reference model.
module tb_sseg_display_ctrl;

   localparam int CLK_DIV      = 8;
   localparam int BLANK_CYCLES = 2;
   localparam int HOLD_FRAMES  = 2;
   localparam int FRAME        = 4 * CLK_DIV;

   localparam logic [6:0] SEG_LUT [16] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
      7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
      7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

   logic        clk;
   logic        rst_n;
   logic [15:0] a_value;
   logic        b_req;
   logic [15:0] b_value;
   logic        b_ack;
   logic        b_done;
   logic        owner;
   logic        frame_tick;
   logic [3:0]  grounds;
   logic [6:0]  display;

   sseg_display_ctrl #(
      .CLK_DIV      (CLK_DIV),
      .BLANK_CYCLES (BLANK_CYCLES),
      .HOLD_FRAMES  (HOLD_FRAMES)
   ) u_dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_a_value    (a_value),
      .i_b_req      (b_req),
      .i_b_value    (b_value),
      .o_b_ack      (b_ack),
      .o_b_done     (b_done),
      .o_owner      (owner),
      .o_frame_tick (frame_tick),
      .o_grounds    (grounds),
      .o_display    (display)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   // reference model: position in frame plus arbitration bookkeeping
   int          m_phase;
   int          m_last_slot;
   logic [15:0] m_shadow;
   logic        m_owner;
   int          m_frames;
   logic [3:0]  e_gnd;
   logic [6:0]  e_disp;
   logic        e_ack, e_done, e_tick, e_owner;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_phase = 0; m_last_slot = CLK_DIV; m_shadow = 16'h0; m_owner = 1'b0; m_frames = 0;
      e_gnd = 4'hF; e_disp = 7'h0; e_ack = 0; e_done = 0; e_tick = 0; e_owner = 0;
      cyc = 0;
   endtask

   task automatic model_grant();
      m_shadow = b_value; e_ack = 1'b1; m_frames = HOLD_FRAMES; m_owner = 1'b1;
   endtask

   task automatic model_advance();
      int dg, sl;
      logic [3:0] nib;
      dg = m_phase / CLK_DIV;
      sl = m_phase % CLK_DIV;
      m_last_slot = sl;
      e_gnd = 4'hF;
      e_disp = 7'h0;
      if (sl >= BLANK_CYCLES) begin
         e_gnd[dg] = 1'b0;
         nib = 4'((m_shadow >> (4 * dg)) & 16'hF);
         e_disp = SEG_LUT[nib];
      end
      e_ack = 1'b0;
      e_done = 1'b0;
      e_tick = (m_phase == FRAME - 1);
      if (e_tick) begin
         if (!m_owner) begin
            if (b_req) model_grant();
            else m_shadow = a_value;
         end else if (m_frames > 1) begin
            m_frames--;
         end else begin
            e_done = 1'b1;
            if (b_req) model_grant();
            else begin m_shadow = a_value; m_owner = 1'b0; m_frames = 0; end
         end
      end
      e_owner = m_owner;
      m_phase = (m_phase + 1) % FRAME;
      cyc++;
   endtask

   task automatic compare_all();
      check_val("grounds", 32'(grounds), 32'(e_gnd));
      check_val("display", 32'(display), 32'(e_disp));
      check_val("b_ack", 32'(b_ack), 32'(e_ack));
      check_val("b_done", 32'(b_done), 32'(e_done));
      check_val("owner", 32'(owner), 32'(e_owner));
      check_val("frame_tick", 32'(frame_tick), 32'(e_tick));
      check_val("one_digit", 32'($countones(~grounds) <= 1), 32'd1);
      if (m_last_slot < BLANK_CYCLES) begin
         check_val("blank_gnd", 32'(grounds), 32'hF);
         check_val("blank_disp", 32'(display), 32'h0);
      end
   endtask

   task automatic run_cycle();
      @(posedge clk);
      model_advance();
      @(negedge clk);
      compare_all();
   endtask

   task automatic run_until_phase(input int p, input string tag);
      int n;
      n = 0;
      while (m_phase != p && n < 2 * FRAME) begin run_cycle(); n++; end
      if (m_phase != p) check_val(tag, 32'd0, 32'd1);
   endtask

   initial begin
      int ack_cyc, done_cyc, acks, n;
      bit seen;
      rst_n = 1'b1; a_value = 16'h0; b_req = 1'b0; b_value = 16'h0;
      #2 rst_n = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      compare_all();

      // 1: background value over two frames
      a_value = 16'h1234;
      rst_n = 1'b1;
      model_reset();
      repeat (35) run_cycle();
      check_val("s1_dig0_gnd", 32'(grounds), 32'hE);
      check_val("s1_dig0_seg", 32'(display), 32'b0110011);
      repeat (24) run_cycle();
      check_val("s1_dig3_gnd", 32'(grounds), 32'h7);
      check_val("s1_dig3_seg", 32'(display), 32'b0110000);

      // 3: single B grant
      run_until_phase(13, "s3_align_timeout");
      b_req = 1'b1; b_value = 16'hABCD;
      seen = 0; n = 0;
      while (!seen && n < 2 * FRAME) begin run_cycle(); n++; seen = b_ack; end
      check_val("s3_ack_seen", 32'(seen), 32'd1);
      check_val("s3_ack_phase", 32'(m_phase), 32'd0);
      ack_cyc = cyc;
      b_req = 1'b0;
      acks = 0; done_cyc = -1;
      repeat (100) begin
         run_cycle();
         if (b_ack) acks++;
         if (b_done && done_cyc < 0) done_cyc = cyc;
      end
      check_val("s3_extra_acks", 32'(acks), 32'd0);
      check_val("s3_done_delay", 32'(done_cyc - ack_cyc), 32'd64);
      check_val("s3_owner_back", 32'(owner), 32'd0);

      // 4: continuous request, value changing between grants
      b_req = 1'b1;
      acks = 0;
      repeat (220) begin
         b_value = 16'($urandom);
         run_cycle();
         if (b_done) begin
            check_val("s4_ack_with_done", 32'(b_ack), 32'd1);
            acks++;
         end
      end
      check_val("s4_regrants", 32'(acks), 32'd3);

      // 5: a_value change mid-frame must not tear the frame
      b_req = 1'b0; a_value = 16'h0000;
      n = 0;
      while (owner && n < 4 * FRAME) begin run_cycle(); n++; end
      check_val("s5_owner_a", 32'(owner), 32'd0);
      run_until_phase(CLK_DIV + 3, "s5_align_timeout");
      a_value = 16'hFFFF;
      run_until_phase(3 * CLK_DIV + 3, "s5_dig3_timeout");
      check_val("s5_old_frame", 32'(display), 32'b1111110);
      run_until_phase(3, "s5_next_timeout");
      check_val("s5_new_frame", 32'(display), 32'b1000111);

      // 6: reset in the middle of a grant
      b_req = 1'b1; b_value = 16'h5A5A;
      seen = 0; n = 0;
      while (!seen && n < 2 * FRAME) begin run_cycle(); n++; seen = b_ack; end
      check_val("s6_ack_seen", 32'(seen), 32'd1);
      repeat (10) run_cycle();
      rst_n = 1'b0;
      model_reset();
      #1;
      compare_all();
      repeat (3) begin @(posedge clk); @(negedge clk); compare_all(); end
      rst_n = 1'b1;
      model_reset();
      seen = 0; n = 0;
      while (!seen && n < 2 * FRAME) begin run_cycle(); n++; seen = b_ack; end
      check_val("s6_ack_cycle", 32'(cyc), 32'd32);

      // random traffic
      repeat (2500) begin
         if ($urandom_range(0, 19) == 0) a_value = 16'($urandom);
         if ($urandom_range(0, 39) == 0) b_req = ~b_req;
         b_value = 16'($urandom);
         run_cycle();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/sseg_display_ctrl.md
# sseg_display_ctrl

Scan controller and source arbiter for the 4-digit multiplexed seven-segment display. It time-multiplexes the four digit grounds with a programmable slot length and an anti-ghosting blank interval. It decodes hex nibbles to segments and shares the display between a background source (A) and a priority one-shot source (B). It sits between the value-producing logic (counters, status registers) and the board display pins.

## Interface
- CLK_DIV, 50000, clk cycles per digit slot; must be ≥ 2.
- BLANK_CYCLES, 500, cycles at the start of each slot with all digits off; must be < CLK_DIV.
- HOLD_FRAMES, 200, full scan frames a B grant stays on the display; must be ≥ 1.

- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- a_value  in  16  background value, shown whenever B does not own the display.
- b_req  in  1  level request from priority source.
- b_value  in  16  priority value; sampled only in the b_ack cycle.
- b_ack  out  1  one-cycle pulse: b_value latched, B now owns the display.
- b_done  out  1  one-cycle pulse: B grant expired.
- owner  out  1  0 = A, 1 = B.
- frame_tick  out  1  one-cycle pulse on every frame boundary.
- grounds  out  4  active-low digit enables; bit d = digit d.
- display  out  7  active-high segments, order {a,b,c,d,e,f,g}.

## Operation
- The scan counter has two fields: slot_cnt (0..CLK_DIV-1) and digit (0..3). slot_cnt increments every cycle. At CLK_DIV-1 it returns to 0 and digit advances, wrapping 3→0.
- Frame boundary: the cycle with digit==3 and slot_cnt==CLK_DIV-1. frame_tick is high in that cycle.
- Blank phase (slot_cnt < BLANK_CYCLES): grounds=4'b1111, display=7'b0000000.
- On phase: grounds has bit `digit` low, with the others high (digit0 → 4'b1110, digit3 → 4'b0111). display is the decode of shadow[4*digit+3 : 4*digit].
- Decode table:
  - 0:1111110, 1:0110000, 2:1101101, 3:1111001
  - 4:0110011, 5:1011011, 6:1011111, 7:1110000
  - 8:1111111, 9:1111011, A:1110111, b:0011111
  - C:1001110, d:0111101, E:1001111, F:1000111
- The shadow register holds the displayed value. It is written only at frame boundaries, so a frame never tears.
- Arbiter FSM states: A_OWN and B_OWN. All transitions happen only in the frame-boundary cycle.
  - A_OWN, b_req=1: latch b_value into shadow, pulse b_ack, load frames_left=HOLD_FRAMES, go to B_OWN.
  - A_OWN, b_req=0: latch a_value into shadow.
  - B_OWN, frames_left>1: decrement frames_left; shadow is unchanged.
  - B_OWN, frames_left==1, b_req=0: pulse b_done, latch a_value, go to A_OWN.
  - B_OWN, frames_left==1, b_req=1: pulse b_done and b_ack in the same cycle, latch the new b_value, reload HOLD_FRAMES, stay in B_OWN.
- b_req dropping during B_OWN does not shorten the grant. A b_req pulse that is low at the boundary is ignored; there is no request memory.
- owner reflects the FSM state.

## Timing
- Reset (async assert, sync-free release), all values: slot_cnt=0, digit=0, shadow=0, A_OWN, frames_left=0, grounds=4'b1111, display=0, b_ack=0, b_done=0, owner=0, frame_tick=0.
- grounds and display are registered. In cycle n+1 they reflect the counter and shadow state of cycle n, a fixed one-cycle latency.
- b_ack, b_done, frame_tick and owner are registered from the boundary decision:
  - the pulses are high in the cycle after the boundary cycle;
  - owner changes in that same cycle.
- Cycle counting after reset: the first posedge after rst_n rises is cycle 0 (slot_cnt=0). The first boundary is cycle 4·CLK_DIV−1, and boundaries repeat every 4·CLK_DIV cycles.
- A change on a_value mid-frame becomes visible in the frame after the next boundary.
- Reset asserted mid-grant: all state clears immediately, and no b_done is issued. A b_req held across reset is acked at the first boundary after release.

## Test plan
Parameters for all scenarios: CLK_DIV=8, BLANK_CYCLES=2, HOLD_FRAMES=2, giving a frame of 32 cycles.

1. Reset, then hold a_value=16'h1234 and run 2 frames.
   - Second frame, digit0 on phase: grounds=1110, display=0110011.
   - Second frame, digit3 on phase: grounds=0111, display=0110000.
2. Blanking: in every slot, at the 2 output cycles following slot_cnt=0,1, require grounds=1111 and display=0000000.
   - Never two ground bits low at once.
3. Assert b_req mid-frame with b_value=16'hABCD, and drop it after b_ack.
   - b_ack exactly once, the cycle after the next boundary.
   - Display then shows d,C,b,A on digits 0..3 for 2 frames.
   - b_done 64 cycles after b_ack; owner returns to 0; a_value digits resume.
4. Hold b_req high continuously, changing b_value between grants.
   - b_done and b_ack coincide every 64 cycles.
   - Each grant shows the value present in its ack cycle; owner stays 1.
5. Change a_value from 16'h0000 to 16'hFFFF at slot 3 of digit 1.
   - Remainder of that frame still shows 0.
   - Next frame shows F (1000111) on all digits.
6. Pull rst_n low 10 cycles into a B grant.
   - All outputs at reset values in the same cycle; no b_done.
   - After release, with b_req held, b_ack occurs at cycle 4·8−1+1=32.
